// File: rtl/npc_patrol_array_if.sv
// npc_patrol_array_if: frame/attack inputs and packed enemy status outputs
interface npc_patrol_array_if #(
    parameter int N_ENEMY = 4
);
    logic                   frame_tick;
    logic                   enable;
    logic                   attack_valid;
    logic [9:0]             attack_x;
    logic [9:0]             attack_y;
    logic [N_ENEMY*10-1:0]  enemy_x;
    logic [N_ENEMY*10-1:0]  enemy_y;
    logic [N_ENEMY*2-1:0]   enemy_state;
    logic [N_ENEMY*4-1:0]   enemy_life;
    logic [7:0]             kill_count;
    logic                   all_dead;

    modport master (
        output frame_tick, enable, attack_valid, attack_x, attack_y,
        input  enemy_x, enemy_y, enemy_state, enemy_life, kill_count, all_dead
    );
    modport slave (
        input  frame_tick, enable, attack_valid, attack_x, attack_y,
        output enemy_x, enemy_y, enemy_state, enemy_life, kill_count, all_dead
    );
endinterface

// File: rtl/npc_patrol_array.sv
// npc_patrol_array: per-frame patrol, hit, hurt and respawn logic for a row of enemies
module npc_patrol_array #(
    parameter int N_ENEMY        = 4,
    parameter int MAX_LIFE       = 3,
    parameter int HURT_FRAMES    = 16,
    parameter int RESPAWN_FRAMES = 120,
    parameter int SPEED          = 2,
    parameter int Y_MIN          = 100,
    parameter int Y_MAX          = 380,
    parameter int X_BASE         = 80,
    parameter int X_SPACING      = 120,
    parameter int ENEMY_SIZE     = 32,
    parameter int ATK_SIZE       = 24
) (
    input logic              Clk,
    input logic              Reset,
    npc_patrol_array_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, PATROL = 2'b01, HURT = 2'b10, DEAD = 2'b11} state_t;

    logic             upd;
    logic [N_ENEMY-1:0] die_v;
    logic [N_ENEMY-1:0] dead_v;
    logic [7:0]       kill_q, kill_d;
    logic [8:0]       kill_sum;
    logic [10:0]      ax, ay;

    assign upd = bus.frame_tick && bus.enable;
    assign ax  = {1'b0, bus.attack_x};
    assign ay  = {1'b0, bus.attack_y};

    for (genvar g = 0; g < N_ENEMY; g++) begin : g_enemy
        localparam logic [9:0] X0 = 10'(X_BASE + g * X_SPACING);
        state_t      st_q, st_d;
        logic [9:0]  x_q;
        logic [9:0]  y_q, y_d;
        logic        up_q, up_d;
        logic [3:0]  life_q, life_d;
        logic [15:0] tmr_q, tmr_d;
        logic [10:0] ex, ey;
        logic        hit, die;

        assign ex  = {1'b0, x_q};
        assign ey  = {1'b0, y_q};
        assign hit = bus.attack_valid && st_q == PATROL
                  && ax < ex + 11'(ENEMY_SIZE) && ex < ax + 11'(ATK_SIZE)
                  && ay < ey + 11'(ENEMY_SIZE) && ey < ay + 11'(ATK_SIZE);

        // next-state: hit beats movement; hurt and dead count down and leave when the timer reads 1
        always_comb begin
            st_d   = st_q;
            y_d    = y_q;
            up_d   = up_q;
            life_d = life_q;
            tmr_d  = tmr_q;
            die    = 1'b0;
            case (st_q)
                IDLE: st_d = PATROL;
                PATROL: begin
                    if (hit) begin
                        if (life_q > 4'd1) begin
                            life_d = life_q - 1'b1;
                            st_d   = HURT;
                            tmr_d  = 16'(HURT_FRAMES);
                        end else begin
                            life_d = 4'd0;
                            st_d   = DEAD;
                            tmr_d  = 16'(RESPAWN_FRAMES);
                            die    = 1'b1;
                        end
                    end else if (!up_q) begin
                        y_d  = ey + 11'(SPEED) >= 11'(Y_MAX) ? 10'(Y_MAX) : y_q + 10'(SPEED);
                        up_d = ey + 11'(SPEED) >= 11'(Y_MAX);
                    end else begin
                        y_d  = ey <= 11'(Y_MIN + SPEED) ? 10'(Y_MIN) : y_q - 10'(SPEED);
                        up_d = !(ey <= 11'(Y_MIN + SPEED));
                    end
                end
                HURT: begin
                    tmr_d = tmr_q <= 16'd1 ? 16'd0 : tmr_q - 1'b1;
                    st_d  = tmr_q <= 16'd1 ? PATROL : HURT;
                end
                DEAD: begin
                    tmr_d = tmr_q <= 16'd1 ? 16'd0 : tmr_q - 1'b1;
                    if (tmr_q <= 16'd1) begin
                        st_d   = PATROL;
                        life_d = 4'(MAX_LIFE);
                        y_d    = 10'(Y_MIN);
                        up_d   = 1'b0;
                    end
                end
            endcase
        end

        // per-enemy registers, advanced only on enabled frame ticks
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                st_q   <= IDLE;
                x_q    <= X0;
                y_q    <= 10'(Y_MIN);
                up_q   <= 1'b0;
                life_q <= 4'(MAX_LIFE);
                tmr_q  <= 16'd0;
            end else if (upd) begin
                st_q   <= st_d;
                y_q    <= y_d;
                up_q   <= up_d;
                life_q <= life_d;
                tmr_q  <= tmr_d;
            end
        end

        assign die_v[g]                  = die;
        assign dead_v[g]                 = st_q == DEAD;
        assign bus.enemy_x[10*g +: 10]   = x_q;
        assign bus.enemy_y[10*g +: 10]   = y_q;
        assign bus.enemy_state[2*g +: 2] = st_q;
        assign bus.enemy_life[4*g +: 4]  = life_q;
    end

    // add every enemy dying this frame, clamp at 255
    always_comb begin
        kill_sum = {1'b0, kill_q};
        for (int i = 0; i < N_ENEMY; i++) kill_sum = kill_sum + {8'd0, die_v[i]};
        kill_d = kill_sum > 9'd255 ? 8'd255 : kill_sum[7:0];
    end

    // kill counter register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) kill_q <= 8'd0;
        else if (upd) kill_q <= kill_d;
    end

    assign bus.kill_count = kill_q;
    assign bus.all_dead   = &dead_v;
endmodule

// File: doc/npc_patrol_array.md
NPC_PATROL_ARRAY -- requirements
Module: npc_patrol_array

Interface
REQ-001 Parameter N_ENEMY, default 4: number of enemy channels, range 1-8.
REQ-002 Parameter MAX_LIFE, default 3: life loaded at reset and at respawn, range 1-15.
REQ-003 Parameter HURT_FRAMES, default 16: frames an enemy stays in HURT.
REQ-004 Parameter RESPAWN_FRAMES, default 120: frames an enemy stays in DEAD.
REQ-005 Parameter SPEED, default 2: pixels moved per frame.
REQ-006 Parameters Y_MIN, default 100, and Y_MAX, default 380: patrol limits for the top-left corner.
REQ-007 Parameters X_BASE, default 80, and X_SPACING, default 120: enemy i column is X_BASE+i*X_SPACING.
REQ-008 Parameters ENEMY_SIZE, default 32, and ATK_SIZE, default 24: square box edge lengths in pixels.
REQ-009 Clk  input  1  system clock; one clock domain.
REQ-010 Reset  input  1  asynchronous, active-high.
REQ-011 frame_tick  input  1  one-Clk pulse per video frame.
REQ-012 enable  input  1  gates all frame updates.
REQ-013 attack_valid  input  1  player attack active.
REQ-014 attack_x, attack_y  input  10 each  attack box top-left corner.
REQ-015 enemy_x, enemy_y  output  N_ENEMY*10 each  packed positions; enemy i occupies bits [10i+9:10i].
REQ-016 enemy_state  output  N_ENEMY*2  per-enemy state: 00 IDLE, 01 PATROL, 10 HURT, 11 DEAD.
REQ-017 enemy_life  output  N_ENEMY*4  per-enemy remaining life.
REQ-018 kill_count  output  8  total kills, saturating.
REQ-019 all_dead  output  1  high while every enemy is in DEAD.

Function
REQ-020 All state updates occur only on a Clk edge with frame_tick=1 and enable=1; otherwise every register holds its value.
REQ-021 All outputs except all_dead are registered; all_dead is combinational from the registered enemy_state.
REQ-022 IDLE: on the next update, go to PATROL with no movement on that update.
REQ-023 PATROL, moving down: y_next=y+SPEED; if y_next>=Y_MAX, load Y_MAX and set direction up.
REQ-024 PATROL, moving up: if y<=Y_MIN+SPEED, load Y_MIN and set direction down; otherwise y_next=y-SPEED.
REQ-025 Hit test on each update:
  - condition: attack_valid=1, state=PATROL, and the two boxes overlap;
  - overlap means ax<ex+ENEMY_SIZE, ex<ax+ATK_SIZE, ay<ey+ENEMY_SIZE and ey<ay+ATK_SIZE;
  - positions are the pre-update values; comparisons use 11-bit unsigned arithmetic.
REQ-026 A hit takes priority over movement; the enemy does not move on the update in which it is hit.
REQ-027 Hit with life>1: decrement life, go to HURT, load hurt timer with HURT_FRAMES.
REQ-028 Hit with life=1: set life to 0, go to DEAD, load respawn timer with RESPAWN_FRAMES.
REQ-029 HURT: position frozen; attacks ignored; timer decrements each update; leave for PATROL on the update where the timer reads 1.
REQ-030 DEAD: attacks ignored; timer decrements each update; at expiry go to PATROL with life=MAX_LIFE, y=Y_MIN, direction down.
REQ-031 kill_count increases by the number of enemies entering DEAD on the same update and saturates at 255.
REQ-032 Several enemies hit on the same update are each processed independently.
REQ-033 x positions are constant per channel and never change.

Reset
REQ-034 While Reset=1, every enemy i is set to:
  - state IDLE, x=X_BASE+i*X_SPACING, y=Y_MIN, direction down;
  - life MAX_LIFE, both timers 0;
  - and kill_count=0.
REQ-035 Reset asserted mid-operation (any state, any timer value) forces the values in REQ-034 immediately, independent of Clk.

Verification
REQ-036 Reset pulse -> enemy x=80/200/320/440, y=100, state 00, life 3, kill_count 0, all_dead 0.
REQ-037 enable=1, 141 ticks -> tick 1 enters PATROL at y=100; tick 141 reaches y=380 and turns up; tick 142 gives y=378.
REQ-038 enable=0 with 10 ticks, then attack at (80,100) with valid=1 and enable=1 while enemy 0 is in PATROL at y=100:
  - the 10 disabled ticks produce no change;
  - enemy 0 goes to life 2, HURT, frozen for 16 ticks, attacks ignored;
  - enemy 0 returns to PATROL on the 16th tick.
REQ-039 Third successful hit on enemy 0 -> DEAD, kill_count 1; after 120 ticks enemy 0 is PATROL, life 3, y=100.
REQ-040 Enemies 0 and 1 both at life 1, attack box overlapping both, e.g. X_SPACING=20 -> both go DEAD on the same tick, kill_count +2.
REQ-041 Reset during HURT with timer 9 and kill_count 255 -> all values return to REQ-034 without a Clk edge.
